// File: rtl/shoot_ctrl_pkg.sv
// Shared game definitions for the tank shot controller: direction encodings,
// playfield limits, FSM state encoding and a saturating counter helper.
package shoot_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam int GRID_X = 24;
  localparam int GRID_Y = 12;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_SETUP_ENC  = 3'd1;
  localparam logic [2:0] ST_ARM_ENC    = 3'd2;
  localparam logic [2:0] ST_FLIGHT_ENC = 3'd3;
  localparam logic [2:0] ST_COOL_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ARM    = ST_ARM_ENC,
    ST_FLIGHT = ST_FLIGHT_ENC,
    ST_COOL   = ST_COOL_ENC
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge
// pulse. Reusable for any raw keypad input.
//   clk_i   system clock
//   rst_ni  async active-low reset
//   btn_i   raw asynchronous button level
//   press_o one-clk pulse on a rising edge of the debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronized input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/shoot_ctrl.sv
// Firing-side initiator of the bullet handshake. Converts a fire button press
// into a held launch request with latched direction/position, releases it at
// end of flight or hit, then enforces a cooldown.
//   clk_i, rst_ni           clock, async active-low reset
//   enable_i                block enable (low: everything holds)
//   tick_8hz_i              bullet-rate strobe
//   fire_btn_i              raw fire button
//   tank_dir_i/xpos/ypos    current tank pose
//   bul_state_feedback_i    bullet in flight (from bullet module)
//   hit_i                   collision pulse for this bullet
//   bul_state_o             launch/flight request
//   bul_dir_o, launch_*_o   latched shot parameters
//   busy_o                  FSM not idle
//   shots_fired_o           saturating launch count
//
// state  | meaning
// IDLE   | waiting for a legal press
// SETUP  | parameters latched, request edge on the next clk
// ARM    | request high, waiting for feedback (tick timeout)
// FLIGHT | bullet in flight, waiting for feedback fall or hit
// COOL   | request low, counting cooldown ticks
module shoot_ctrl
  import shoot_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 500000,
  parameter int ARM_TIMEOUT    = 4,
  parameter int COOLDOWN_TICKS = 2,
  parameter int X_MAX          = GRID_X,
  parameter int Y_MAX          = GRID_Y
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       tick_8hz_i,
  input  logic       fire_btn_i,
  input  logic [1:0] tank_dir_i,
  input  logic [4:0] tank_xpos_i,
  input  logic [4:0] tank_ypos_i,
  input  logic       bul_state_feedback_i,
  input  logic       hit_i,
  output logic       bul_state_o,
  output logic [1:0] bul_dir_o,
  output logic [4:0] launch_xpos_o,
  output logic [4:0] launch_ypos_o,
  output logic       busy_o,
  output logic [7:0] shots_fired_o
);

  localparam logic [4:0] X_LIM     = 5'(X_MAX);
  localparam logic [4:0] Y_LIM     = 5'(Y_MAX);
  // Tick timers load N-1 and expire on the tick seen at zero.
  localparam logic [7:0] ARM_LOAD  = 8'(ARM_TIMEOUT - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_TICKS - 1);

  logic press;
  logic in_range;

  state_t     state_q;
  dir_t       bul_dir_q;
  logic [4:0] xpos_q, ypos_q;
  logic       bul_state_q;
  logic       busy_q;
  logic [7:0] shots_q;
  logic [7:0] tick_cnt_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_fire_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (fire_btn_i),
    .press_o (press)
  );

  assign in_range = (tank_xpos_i < X_LIM) && (tank_ypos_i < Y_LIM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bul_dir_q   <= DIR_UP;
      xpos_q      <= '0;
      ypos_q      <= '0;
      bul_state_q <= 1'b0;
      busy_q      <= 1'b0;
      shots_q     <= '0;
      tick_cnt_q  <= '0;
    end else if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          if (press && in_range) begin
            bul_dir_q <= dir_t'(tank_dir_i);
            xpos_q    <= tank_xpos_i;
            ypos_q    <= tank_ypos_i;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bul_state_q <= 1'b1;
          shots_q     <= sat_inc8(shots_q);
          tick_cnt_q  <= ARM_LOAD;
          state_q     <= ST_ARM;
        end
        ST_ARM: begin
          if (hit_i || (tick_8hz_i && !bul_state_feedback_i && tick_cnt_q == 8'd0)) begin
            bul_state_q <= 1'b0;
            tick_cnt_q  <= COOL_LOAD;
            state_q     <= ST_COOL;
          end else if (bul_state_feedback_i) begin
            state_q <= ST_FLIGHT;
          end else if (tick_8hz_i) begin
            tick_cnt_q <= tick_cnt_q - 8'd1;
          end
        end
        ST_FLIGHT: begin
          // FLIGHT is only entered with feedback high, so a low level here is
          // the falling edge; a coincident hit folds into the same event.
          if (hit_i || !bul_state_feedback_i) begin
            bul_state_q <= 1'b0;
            tick_cnt_q  <= COOL_LOAD;
            state_q     <= ST_COOL;
          end
        end
        ST_COOL: begin
          if (tick_8hz_i) begin
            if (tick_cnt_q == 8'd0) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          bul_state_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bul_state_o   = bul_state_q;
  assign bul_dir_o     = bul_dir_q;
  assign launch_xpos_o = xpos_q;
  assign launch_ypos_o = ypos_q;
  assign busy_o        = busy_q;
  assign shots_fired_o = shots_q;

endmodule

// File: tb/tb_shoot_ctrl.sv
module tb_shoot_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       fire = 1'b0;
  logic [1:0] tdir = 2'b00;
  logic [4:0] tx = 5'd0;
  logic [4:0] ty = 5'd0;
  logic       fb = 1'b0;
  logic       hit = 1'b0;
  logic       bul_state;
  logic [1:0] bul_dir;
  logic [4:0] lx, ly;
  logic       busy;
  logic [7:0] shots;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] dir;
    logic [4:0] x;
    logic [4:0] y;
    logic [7:0] shots;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shoot_ctrl #(
    .DEBOUNCE_CYC(4), .ARM_TIMEOUT(4), .COOLDOWN_TICKS(2), .X_MAX(24), .Y_MAX(12)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .tick_8hz_i(tick),
    .fire_btn_i(fire), .tank_dir_i(tdir), .tank_xpos_i(tx), .tank_ypos_i(ty),
    .bul_state_feedback_i(fb), .hit_i(hit), .bul_state_o(bul_state),
    .bul_dir_o(bul_dir), .launch_xpos_o(lx), .launch_ypos_o(ly),
    .busy_o(busy), .shots_fired_o(shots)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every rising edge of bul_state is a launch; pop the expected
  // record and check it, plus that the parameters were already stable in the
  // preceding (SETUP) cycle.
  logic       prev_bs = 1'b0;
  logic [1:0] prev_dir = 2'b00;
  logic [4:0] prev_x = 5'd0, prev_y = 5'd0;
  always @(negedge clk) begin
    if (bul_state && !prev_bs) begin
      if (sb.size() == 0) begin
        check("unexpected_launch", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("launch_dir", bul_dir, e.dir);
        check("launch_x", lx, e.x);
        check("launch_y", ly, e.y);
        check("shots_fired", shots, e.shots);
        check("busy_at_launch", busy, 1);
        check("setup_dir", prev_dir, e.dir);
        check("setup_x", prev_x, e.x);
        check("setup_y", prev_y, e.y);
      end
    end
    prev_bs  = bul_state;
    prev_dir = bul_dir;
    prev_x   = lx;
    prev_y   = ly;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic press();
    fire = 1'b1;
    cyc(12);
    fire = 1'b0;
    cyc(12);
  endtask

  task automatic expect_launch(input logic [1:0] d, input logic [4:0] x,
                               input logic [4:0] y, input logic [7:0] s);
    exp_t e;
    e.dir = d; e.x = x; e.y = y; e.shots = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset values
    cyc(1);
    check("rst_bul_state", bul_state, 0);
    check("rst_busy", busy, 0);
    check("rst_shots", shots, 0);
    check("rst_dir", bul_dir, 0);
    check("rst_x", lx, 0);
    check("rst_y", ly, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    cyc(2);

    // Clean press at (5,3) facing right, feedback round trip, COOL press ignored
    tdir = 2'b11; tx = 5'd5; ty = 5'd3;
    expect_launch(2'b11, 5'd5, 5'd3, 8'd1);
    press();
    check("busy_after_press", busy, 1);
    pulse_tick();
    fb = 1'b1;
    cyc(2);
    check("flight_bul_state", bul_state, 1);
    fb = 1'b0;
    cyc(1);
    check("fb_fall_drop", bul_state, 0);
    check("cool_busy", busy, 1);
    press();
    check("cool_press_no_launch", bul_state, 0);
    pulse_tick();
    check("cool_after_1tick", busy, 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("idle_after_2ticks", busy, 0);
    cyc(2);

    // Bouncy press, then no feedback: timeout after 4 ticks
    tdir = 2'b00; tx = 5'd7; ty = 5'd2;
    expect_launch(2'b00, 5'd7, 5'd2, 8'd2);
    fire = 1'b1; cyc(1); fire = 1'b0; cyc(1); fire = 1'b1;
    cyc(10);
    fire = 1'b0;
    cyc(12);
    check("bouncy_one_shot", shots, 2);
    repeat (3) pulse_tick();
    check("arm_before_timeout", bul_state, 1);
    pulse_tick();
    check("arm_timeout_drop", bul_state, 0);
    check("timeout_cool_busy", busy, 1);
    repeat (2) pulse_tick();
    check("timeout_back_idle", busy, 0);

    // Hit during flight at the last legal cell
    tdir = 2'b10; tx = 5'd23; ty = 5'd11;
    expect_launch(2'b10, 5'd23, 5'd11, 8'd3);
    press();
    fb = 1'b1;
    cyc(2);
    check("hit_pre_bul_state", bul_state, 1);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    check("hit_drop", bul_state, 0);
    fb = 1'b0;
    repeat (2) pulse_tick();
    check("hit_back_idle", busy, 0);

    // Out-of-range presses
    tx = 5'd24; ty = 5'd3;
    press();
    check("x24_ignored", busy, 0);
    tx = 5'd3; ty = 5'd31;
    press();
    check("y31_ignored", busy, 0);
    tx = 5'd5; ty = 5'd12;
    press();
    check("y12_ignored", busy, 0);

    // Press while disabled is discarded
    tx = 5'd2; ty = 5'd2;
    enable = 1'b0;
    press();
    enable = 1'b1;
    cyc(5);
    check("disabled_press_busy", busy, 0);
    check("disabled_press_shots", shots, 3);

    // Mid-flight reset drops the request asynchronously
    tdir = 2'b01; tx = 5'd1; ty = 5'd1;
    expect_launch(2'b01, 5'd1, 5'd1, 8'd4);
    press();
    fb = 1'b1;
    cyc(2);
    check("pre_reset_flight", bul_state, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", bul_state, 0);
    check("async_reset_shots", shots, 0);
    check("async_reset_busy", busy, 0);
    fb = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Saturation: 256 launches with timeout each
    for (int i = 0; i < 256; i++) begin
      tdir = 2'(i % 4);
      tx   = 5'(i % 24);
      ty   = 5'(i % 12);
      expect_launch(tdir, tx, ty, (i >= 254) ? 8'd255 : 8'(i + 1));
      press();
      repeat (6) pulse_tick();
    end
    check("shots_saturated", shots, 255);
    check("sat_idle", busy, 0);

    cyc(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
